// File: rtl/seq_mul.sv
// rtl/seq_mul.sv - iterative shift-add RISC-V MUL/MULH/MULHSU/MULHU unit
// Optional macro: SEQ_MUL_EARLY_EXIT_EN (leave BUSY once the remaining multiplier is zero)
module seq_mul #(
   parameter int XLEN = 64,
   localparam int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            kill,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] y
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DONE
   } state_t;

   state_t              state;
   logic [1:0]          op_r;
   logic                neg;
   logic [2*XLEN-1:0]   mcand;
   logic [2*XLEN-1:0]   acc;
   logic [XLEN-1:0]     mplier;
   logic [CNT_W-1:0]    cnt;

   logic                sign_a;
   logic                sign_b;
   logic [XLEN-1:0]     abs_a;
   logic [XLEN-1:0]     abs_b;
   logic [2*XLEN-1:0]   acc_sum;
   logic [2*XLEN-1:0]   prod;
   logic                finish;

   // Only the state decides readiness; in_valid never feeds back into in_ready
   assign in_ready = (state == S_IDLE);

   // Operand signs and magnitudes; the datapath itself only ever multiplies magnitudes
   always_comb begin
      sign_a = ((op == 2'b01) || (op == 2'b10)) && a[XLEN-1];
      sign_b = (op == 2'b01) && b[XLEN-1];
      abs_a  = sign_a ? (~a + 1'b1) : a;
      abs_b  = sign_b ? (~b + 1'b1) : b;
   end

   // Full-width partial sum for this step and the sign-corrected product taken from it
   always_comb begin
      acc_sum = acc + (mplier[0] ? mcand : '0);
      prod    = neg ? (~acc_sum + 1'b1) : acc_sum;
`ifdef SEQ_MUL_EARLY_EXIT_EN
      finish  = (cnt == CNT_W'(1)) || (mplier[XLEN-1:1] == '0);
`else
      finish  = (cnt == CNT_W'(1));
`endif
   end

   // Control FSM and datapath; reset beats kill, kill beats accept and out_ready
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         y         <= '0;
         out_valid <= 1'b0;
         cnt       <= '0;
      end else if (kill) begin
         state     <= S_IDLE;
         out_valid <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_r   <= op;
                  mcand  <= {{XLEN{1'b0}}, abs_a};
                  mplier <= abs_b;
                  neg    <= sign_a ^ sign_b;
                  acc    <= '0;
                  cnt    <= CNT_W'(XLEN);
                  state  <= S_BUSY;
               end
            end
            S_BUSY: begin
               acc    <= acc_sum;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt - 1'b1;
               if (finish) begin
                  y         <= (op_r == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                  out_valid <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: begin
               state     <= S_IDLE;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_mul.sv
// tb/tb_seq_mul.sv - randomized and directed self-checking bench for seq_mul
module tb_seq_mul;

   localparam int XLEN = 64;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic            kill;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] y;

   int pass_cnt = 0;
   int total    = 0;

   seq_mul #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .a         (a),
      .b         (b),
      .kill      (kill),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y)
   );

   always #5 clk = ~clk;

   // Reference: exact product of the operands interpreted per op, then half selected
   function automatic logic [63:0] model_y(input logic [1:0] o, input logic [63:0] x, input logic [63:0] z);
      logic signed [129:0] ex;
      logic signed [129:0] ez;
      logic signed [129:0] p;
      ex = (o == 2'd1 || o == 2'd2) ? {{66{x[63]}}, x} : {66'd0, x};
      ez = (o == 2'd1) ? {{66{z[63]}}, z} : {66'd0, z};
      p  = ex * ez;
      return (o == 2'd0) ? p[63:0] : p[127:64];
   endfunction

   // Reference: cycle index (accept = cycle 0) of the first out_valid
   function automatic int model_lat(input logic [1:0] o, input logic [63:0] z);
      int busy;
`ifdef SEQ_MUL_EARLY_EXIT_EN
      logic [63:0] mb;
      mb   = (o == 2'd1 && z[63]) ? (~z + 64'd1) : z;
      busy = 1;
      for (int i = 0; i < 64; i++)
         if (mb[i]) busy = i + 1;
`else
      busy = 64;
`endif
      return busy + 1;
   endfunction

   task automatic start_op(input logic [1:0] o, input logic [63:0] x, input logic [63:0] z);
      in_valid = 1'b1;
      op = o;
      a  = x;
      b  = z;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = 1;
      while (!out_valid && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
      op = 2'd0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 64'd0)
         $display("FAIL reset: in_ready=%b out_valid=%b y=%h, required 1 0 0", in_ready, out_valid, y);
      else pass_cnt++;
   endtask

   typedef struct {
      logic [1:0]  o;
      logic [63:0] x;
      logic [63:0] z;
      logic [63:0] e;
   } vec_t;

   task automatic test_directed();
      vec_t v [8];
      int lat;
      v[0] = '{2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
      v[1] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
      v[2] = '{2'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000};
      v[3] = '{2'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
      v[4] = '{2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
      v[5] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 64'hFFFF_FFFF_FFFF_FFF1};
      v[6] = '{2'd3, 64'd5, 64'd3, 64'd0};
      v[7] = '{2'd0, 64'd5, 64'd0, 64'd0};
      for (int i = 0; i < 8; i++) begin
         start_op(v[i].o, v[i].x, v[i].z);
         wait_done(lat);
         total++;
         if (y !== v[i].e || out_valid !== 1'b1)
            $display("FAIL directed_y[%0d]: y=%h out_valid=%b, required %h 1", i, y, out_valid, v[i].e);
         else pass_cnt++;
         total++;
         if (lat != model_lat(v[i].o, v[i].z))
            $display("FAIL directed_lat[%0d]: cycle=%0d, required %0d", i, lat, model_lat(v[i].o, v[i].z));
         else pass_cnt++;
         total++;
         if (in_ready !== 1'b0)
            $display("FAIL directed_ready_done[%0d]: in_ready=%b, required 0", i, in_ready);
         else pass_cnt++;
         handshake();
         total++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL directed_release[%0d]: out_valid=%b in_ready=%b, required 0 1", i, out_valid, in_ready);
         else pass_cnt++;
      end
   endtask

   task automatic test_random();
      logic [1:0]  o;
      logic [63:0] x;
      logic [63:0] z;
      int lat;
      for (int i = 0; i < 20; i++) begin
         o = 2'($urandom_range(0, 3));
         x = {$urandom, $urandom};
         z = {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) z = 64'($urandom_range(0, 15));
         if ($urandom_range(0, 5) == 0) x = 64'h8000_0000_0000_0000;
         start_op(o, x, z);
         wait_done(lat);
         total++;
         if (y !== model_y(o, x, z) || lat != model_lat(o, z))
            $display("FAIL random[%0d] op=%0d a=%h b=%h: y=%h cycle=%0d, required %h %0d",
                     i, o, x, z, y, lat, model_y(o, x, z), model_lat(o, z));
         else pass_cnt++;
         handshake();
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] x1, z1, x2, z2;
      logic [63:0] e1;
      int lat;
      x1 = {$urandom, $urandom}; z1 = {$urandom, $urandom};
      x2 = {$urandom, $urandom}; z2 = {$urandom, $urandom};
      e1 = model_y(2'd0, x1, z1);
      start_op(2'd0, x1, z1);
      wait_done(lat);
      in_valid = 1'b1; op = 2'd3; a = x2; b = z2;
      for (int k = 0; k < 5; k++) begin
         total++;
         if (out_valid !== 1'b1 || y !== e1 || in_ready !== 1'b0)
            $display("FAIL backpressure_hold[%0d]: out_valid=%b y=%h in_ready=%b, required 1 %h 0", k, out_valid, y, in_ready, e1);
         else pass_cnt++;
         @(posedge clk);
         #1;
      end
      handshake();
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL backpressure_no_accept: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      else pass_cnt++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      total++;
      if (in_ready !== 1'b0)
         $display("FAIL backpressure_accept_next: in_ready=%b, required 0", in_ready);
      else pass_cnt++;
      wait_done(lat);
      total++;
      if (y !== model_y(2'd3, x2, z2) || lat != model_lat(2'd3, z2))
         $display("FAIL backpressure_second: y=%h cycle=%0d, required %h %0d", y, lat, model_y(2'd3, x2, z2), model_lat(2'd3, z2));
      else pass_cnt++;
      handshake();
   endtask

   task automatic test_kill_reset();
      bit seen = 1'b0;
      int lat;
      // kill in BUSY cycle 10
      start_op(2'd3, {$urandom, $urandom}, 64'hFFFF_FFFF_FFFF_FFFF);
      for (int c = 1; c < 10; c++) begin
         seen |= out_valid;
         @(posedge clk);
         #1;
      end
      kill = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL kill_busy: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
      else pass_cnt++;
      // reset in BUSY cycle 20
      start_op(2'd1, {$urandom, $urandom}, 64'hFFFF_FFFF_FFFF_FFFF);
      for (int c = 1; c < 20; c++) begin
         seen |= out_valid;
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || y !== 64'd0)
         $display("FAIL reset_busy: in_ready=%b out_valid=%b y=%h, required 1 0 0", in_ready, out_valid, y);
      else pass_cnt++;
      for (int c = 0; c < 70; c++) begin
         seen |= out_valid;
         @(posedge clk);
         #1;
      end
      total++;
      if (seen !== 1'b0)
         $display("FAIL kill_reset_no_valid: out_valid seen=%b, required 0", seen);
      else pass_cnt++;
      // kill in IDLE blocks acceptance
      kill = 1'b1;
      start_op(2'd0, 64'd7, 64'd6);
      kill = 1'b0;
      total++;
      if (in_ready !== 1'b1)
         $display("FAIL kill_idle_block: in_ready=%b, required 1", in_ready);
      else pass_cnt++;
      start_op(2'd0, 64'd7, 64'd6);
      wait_done(lat);
      total++;
      if (y !== 64'd42 || out_valid !== 1'b1)
         $display("FAIL mul_7x6: y=%0d out_valid=%b, required 42 1", y, out_valid);
      else pass_cnt++;
      // kill in DONE discards the result
      kill = 1'b1;
      @(posedge clk);
      #1;
      kill = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL kill_done: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_kill_reset();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
